mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 24 ++
 rtl/settle_timer.sv | 42 ++++
 rtl/mux_scan_sequencer.sv | 140 ++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the mux scan sequencer.
//   NUM_CH         : channels scanned per frame (fixed at 4)
//   SEL_W          : mux select width, clog2(NUM_CH)
//   SETTLE_CYC_DEF : default settle time per channel, in cycles
//   state_t        : sequencer FSM state
//   frame_t        : one assembled frame, bit k = sample of channel k
// -----------------------------------------------------------------------------
package mux_scan_pkg;

  localparam int NUM_CH         = 4;
  localparam int SEL_W          = $clog2(NUM_CH);
  localparam int SETTLE_CYC_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  typedef logic [NUM_CH-1:0] frame_t;

endpackage : mux_scan_pkg

// File: rtl/settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Free-running settle counter that restarts from zero whenever clr is high.
// tick is high for the one cycle in which the count equals SETTLE_CYC-1; the
// counter returns to zero on that same edge, so ticks repeat every
// SETTLE_CYC cycles while clr stays low.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   clr  : hold the counter at zero (sequencer not scanning)
//   tick : settle time elapsed, sample the current channel this edge
// -----------------------------------------------------------------------------
module settle_timer #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !clr && (cnt == LAST);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : settle_timer

// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
// Steps the select of an external 4:1 mux through every channel, waits
// SETTLE_CYC cycles on each, samples the mux output, and offers the assembled
// 4-bit frame over a valid/ready handshake. Single-shot or continuous scan.
//
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   start       : begin a scan (looked at only while idle)
//   cont_mode   : rescan automatically after each accepted frame (looked at
//                 on the handshake edge)
//   sel         : mux select
//   y_in        : mux output
//   frame_data  : bit k = sample of channel k
//   frame_valid : frame_data holds a complete frame
//   frame_ready : consumer accepts the frame
//   busy        : scanning or presenting
//   frame_count : accepted frames, modulo 2**FCNT_W
// -----------------------------------------------------------------------------
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int CNT_W      = 4,
  parameter int FCNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont_mode,
  output logic [SEL_W-1:0]  sel,
  input  logic              y_in,
  output frame_t            frame_data,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_count
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  frame_t              shadow_q, shadow_d;
  frame_t              frame_data_q, frame_data_d;
  logic                frame_valid_q, frame_valid_d;
  logic [FCNT_W-1:0]   frame_count_q, frame_count_d;
  logic                tick;

  // Counter runs only while scanning, so every entry into SCAN starts at zero.
  settle_timer #(
    .SETTLE_CYC (SETTLE_CYC),
    .CNT_W      (CNT_W)
  ) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != SCAN),
    .tick (tick)
  );

  // NOTE: every signal assigned here gets its default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    frame_count_d = frame_count_q;

    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (start) begin
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (tick) begin
          shadow_d[sel_q] = y_in;
          if (sel_q == LAST_SEL) begin
            // The last channel goes straight into the frame; the shadow only
            // needs to carry the earlier channels.
            frame_data_d  = {y_in, shadow_q[NUM_CH-2:0]};
            frame_valid_d = 1'b1;
            state_d       = PRESENT;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end

      PRESENT: begin
        // frame_valid is always set in this state, so ready alone is the
        // handshake.
        if (frame_ready) begin
          frame_count_d = frame_count_q + 1'b1;
          frame_valid_d = 1'b0;
          sel_d         = '0;
          state_d       = cont_mode ? SCAN : IDLE;
        end
      end

      default: begin
        state_d       = IDLE;
        sel_d         = '0;
        frame_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: the shadow register is small and is cleared on reset so a
  // discarded partial frame can never leak into a later one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign sel         = sel_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;
  assign busy        = (state_q != IDLE);

endmodule : mux_scan_sequencer

// File: tb/tb_mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_sequencer
// Bench for mux_scan_sequencer with a behavioural 4:1 mux closing the loop
// (y_in = mux_i[sel]). Stimulus pushes each expected frame into a queue; a
// monitor pops and compares on every handshake and tracks the expected frame
// count independently.
// -----------------------------------------------------------------------------
module tb_mux_scan_sequencer;
  import mux_scan_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cont_mode;
  logic [SEL_W-1:0] sel;
  logic             y_in;
  frame_t           frame_data;
  logic             frame_valid;
  logic             frame_ready;
  logic             busy;
  logic [7:0]       frame_count;

  frame_t           mux_i;
  frame_t           exp_q[$];
  logic [7:0]       model_count = 8'd0;
  int               n_pass   = 0;
  int               n_checks = 0;

  always #5 clk = ~clk;

  assign y_in = mux_i[sel];

  mux_scan_sequencer #(
    .SETTLE_CYC (2),
    .CNT_W      (4),
    .FCNT_W     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cont_mode   (cont_mode),
    .sel         (sel),
    .y_in        (y_in),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .frame_count (frame_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // sel, frame_valid, busy, frame_count and frame_data all zero.
  task automatic check_cleared(input string name);
    check(name, 32'({sel, frame_valid, busy, frame_count, frame_data}), 32'd0);
  endtask

  // Tick until frame_valid is seen, bounded; n = ticks taken.
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!frame_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: samples between the input-drive edge and the next
  // rising edge, so a handshake seen here happens on the coming edge.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      model_count = 8'd0;
    end else if (frame_valid && frame_ready) begin
      check("sb_frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("frame_data", 32'(frame_data), 32'(exp_q.pop_front()));
      end
      check("frame_count_at_hs", 32'(frame_count), 32'(model_count));
      model_count = model_count + 8'd1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst         = 1'b1;
    start       = 1'b0;
    cont_mode   = 1'b0;
    frame_ready = 1'b0;
    mux_i       = 4'b0000;

    // 1. Reset then idle.
    repeat (3) tick();
    check_cleared("reset_hold");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_cleared("idle_no_start");
    end

    // 2. Single shot, sel stepping and latency.
    mux_i       = 4'b1010;
    frame_ready = 1'b1;
    exp_q.push_back(4'b1010);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ss_busy_after_start", 32'(busy), 32'd1);
    check("ss_sel_edge0", 32'({sel, frame_valid}), 32'({2'd0, 1'b0}));
    for (int j = 1; j < 8; j++) begin
      tick();
      check("ss_sel_step", 32'({sel, frame_valid}), 32'({2'(j / 2), 1'b0}));
    end
    tick();
    check("ss_valid_at_t8", 32'({frame_valid, sel}), 32'({1'b1, 2'd3}));
    tick();
    check("ss_back_idle", 32'({busy, frame_valid, sel, frame_count}), 32'({1'b0, 1'b0, 2'd0, 8'd1}));

    // 3. Backpressure, ignored late start.
    do_reset();
    mux_i       = 4'b0110;
    frame_ready = 1'b0;
    exp_q.push_back(4'b0110);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(20, n);
    check("bp_latency", 32'(n), 32'd8);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) start = 1'b1;
      if (i == 5) start = 1'b0;
      tick();
      check("bp_hold", 32'({frame_valid, frame_data, sel}), 32'({1'b1, 4'b0110, 2'd3}));
    end
    frame_ready = 1'b1;
    tick();
    check("bp_handshake", 32'({busy, frame_valid, frame_count}), 32'({1'b0, 1'b0, 8'd1}));
    repeat (3) tick();
    check("bp_start_not_queued", 32'(busy), 32'd0);

    // 4. Continuous mode, two frames, then drop back to idle.
    do_reset();
    cont_mode   = 1'b1;
    frame_ready = 1'b1;
    mux_i       = 4'b0001;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1110);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(20, n);
    check("cont_latency", 32'(n), 32'd8);
    tick();
    check("cont_rescan", 32'({busy, frame_valid, sel}), 32'({1'b1, 1'b0, 2'd0}));
    mux_i = 4'b1110;
    wait_valid(20, n);
    check("cont_spacing", 32'(n + 1), 32'd9);
    cont_mode = 1'b0;
    tick();
    check("cont_exit_idle", 32'({busy, frame_valid, frame_count}), 32'({1'b0, 1'b0, 8'd2}));

    // 5. Asynchronous reset mid-scan.
    check("sb_drained_t5", 32'(exp_q.size()), 32'd0);
    mux_i = 4'b1011;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid_scan_sel", 32'(sel), 32'd2);
    #1 rst = 1'b1;
    #1 check_cleared("async_reset");
    @(negedge clk);
    tick();
    rst = 1'b0;
    exp_q.push_back(4'b1011);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(20, n);
    check("post_rst_latency", 32'(n), 32'd8);
    tick();
    check("post_rst_count", 32'({busy, frame_count}), 32'({1'b0, 8'd1}));

    // 6. Frame counter wrap.
    do_reset();
    cont_mode   = 1'b1;
    frame_ready = 1'b1;
    mux_i       = 4'b0101;
    for (int f = 0; f < 257; f++) exp_q.push_back(4'b0101);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int f = 0; f < 257; f++) begin
      wait_valid(20, n);
      check("wrap_frame_period", 32'(n), 32'd8);
      if (f == 256) cont_mode = 1'b0;
      tick();
      if (f == 255) check("wrap_to_zero", 32'(frame_count), 32'd0);
    end
    check("wrap_frame_257", 32'({busy, frame_count}), 32'({1'b0, 8'd1}));
    check("sb_drained_end", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mux_scan_sequencer
